// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, state encoding and shared constants for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam int DUMMY_CLKS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DOUT,
        ST_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_ID,
        SRC_ZERO
    } src_e;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with single-cycle rise/fall event outputs.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-cycle pulses when q changes 0->1 / 1->0
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    // One flop beyond the synchronizer holds the previous level for edge detection.
    logic [STAGES:0] sync_q, sync_d;

    assign sync_d = {sync_q[STAGES-1:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {(STAGES+1){RST_VAL}};
        else        sync_q <= sync_d;
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~sync_q[STAGES];
    assign fall = ~q & sync_q[STAGES];

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target serving READ/FAST/QUAD READ, RDID and RDSR from a memory port.
//   clk, rst_n     : system clock (>= 4x sclk), asynchronous active-low reset
//   sclk, cs_n     : SPI clock and chip select from the master
//   qdi            : io3..io0 pad inputs, only qdi[0] (MOSI) is used
//   qdo, oe        : io3..io0 output data and per-lane output enable
//   mem_addr       : byte address to backing memory
//   mem_rd         : one-cycle read strobe
//   mem_data       : read data, valid the cycle after mem_rd
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_BITS   = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic [3:0]           qdi,
    output logic [3:0]           qdo,
    output logic [3:0]           oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data
);

    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CLKS - 1);

    logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, sck_rise, sck_fall, unused_ok;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    assign sck_rise  = sclk_rise & ~cs_s;
    assign sck_fall  = sclk_fall & ~cs_s;
    assign unused_ok = ^{qdi[3:1], sclk_s};

    state_e                 state_q, state_d;
    src_e                   src_q, src_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [22:0]            shift_in_q, shift_in_d;
    logic                   quad_q, quad_d, dummy_q, dummy_d, data_vld_q, data_vld_d, mem_rd_q, mem_rd_d;
    logic [1:0]             id_idx_q, id_idx_d;
    logic [7:0]             out_sh_q, out_sh_d, pref_q, pref_d;
    logic [2:0]             out_cnt_q, out_cnt_d;
    logic [3:0]             qdo_q, qdo_d, oe_q, oe_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;

    logic       mosi_s, in_phase, phase_done;
    logic [4:0] last_bit;
    logic [7:0] opcode, id_byte, load_byte, cur_byte;
    logic [23:0] addr_in;

    assign mosi_s     = mosi_q[SYNC_STAGES-1];
    assign opcode     = {shift_in_q[6:0], mosi_s};
    assign addr_in    = {shift_in_q, mosi_s};
    assign in_phase   = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DUMMY);
    assign last_bit   = (state_q == ST_ADDR) ? 5'd23 : (state_q == ST_DUMMY) ? DUMMY_LAST : 5'd7;
    assign phase_done = bit_cnt_q == last_bit;
    assign id_byte    = (id_idx_q == 2'd0) ? JEDEC_ID[23:16] : (id_idx_q == 2'd1) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
    // The first byte can arrive from memory in the same cycle it is needed, so bypass the prefetch register.
    assign load_byte  = (src_q == SRC_ID) ? id_byte : (src_q == SRC_ZERO) ? 8'h00 : data_vld_q ? mem_data : pref_q;
    assign cur_byte   = (out_cnt_q == 3'd0) ? load_byte : out_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_MEM;
            mosi_q     <= '0;
            bit_cnt_q  <= '0;
            shift_in_q <= '0;
            quad_q     <= 1'b0;
            dummy_q    <= 1'b0;
            data_vld_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            id_idx_q   <= '0;
            out_sh_q   <= '0;
            pref_q     <= '0;
            out_cnt_q  <= '0;
            qdo_q      <= '0;
            oe_q       <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            mosi_q     <= mosi_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_in_q <= shift_in_d;
            quad_q     <= quad_d;
            dummy_q    <= dummy_d;
            data_vld_q <= data_vld_d;
            mem_rd_q   <= mem_rd_d;
            id_idx_q   <= id_idx_d;
            out_sh_q   <= out_sh_d;
            pref_q     <= pref_d;
            out_cnt_q  <= out_cnt_d;
            qdo_q      <= qdo_d;
            oe_q       <= oe_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_IDLE:  if (cs_fall) state_d = ST_CMD;
                ST_CMD:   if (sck_rise && phase_done)
                              state_d = (opcode == OP_READ || opcode == OP_FREAD || opcode == OP_QREAD) ? ST_ADDR :
                                        (opcode == OP_RDID || opcode == OP_RDSR) ? ST_DOUT : ST_IGNORE;
                ST_ADDR:  if (sck_rise && phase_done) state_d = dummy_q ? ST_DUMMY : ST_DOUT;
                ST_DUMMY: if (sck_rise && phase_done) state_d = ST_DOUT;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mosi_d     = SYNC_STAGES'({mosi_q, qdi[0]});
        src_d      = src_q;
        bit_cnt_d  = bit_cnt_q;
        shift_in_d = shift_in_q;
        quad_d     = quad_q;
        dummy_d    = dummy_q;
        id_idx_d   = id_idx_q;
        out_sh_d   = out_sh_q;
        out_cnt_d  = out_cnt_q;
        qdo_d      = qdo_q;
        oe_d       = oe_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        data_vld_d = mem_rd_q;
        pref_d     = data_vld_q ? mem_data : pref_q;
        if (cs_rise) begin
            bit_cnt_d  = '0;
            out_cnt_d  = '0;
            id_idx_d   = '0;
            qdo_d      = '0;
            oe_d       = '0;
            data_vld_d = 1'b0;
            pref_d     = '0;
        end else if (sck_rise && in_phase) begin
            shift_in_d = {shift_in_q[21:0], mosi_s};
            bit_cnt_d  = phase_done ? 5'd0 : bit_cnt_q + 5'd1;
            if (state_q == ST_CMD && phase_done) begin
                quad_d  = opcode == OP_QREAD;
                dummy_d = (opcode == OP_FREAD) || (opcode == OP_QREAD);
                src_d   = (opcode == OP_RDID) ? SRC_ID : (opcode == OP_RDSR) ? SRC_ZERO : SRC_MEM;
            end
            if (state_q == ST_ADDR && phase_done) begin
                mem_addr_d = addr_in[ADDR_BITS-1:0];
                mem_rd_d   = 1'b1;
            end
        end else if (sck_fall && state_q == ST_DOUT) begin
            qdo_d     = quad_q ? cur_byte[7:4] : {2'b00, cur_byte[7], 1'b0};
            oe_d      = quad_q ? 4'b1111 : 4'b0010;
            out_sh_d  = quad_q ? {cur_byte[3:0], 4'h0} : {cur_byte[6:0], 1'b0};
            out_cnt_d = (out_cnt_q == (quad_q ? 3'd1 : 3'd7)) ? 3'd0 : out_cnt_q + 3'd1;
            // Loading a byte immediately prefetches the next one.
            if (out_cnt_q == 3'd0 && src_q == SRC_MEM) begin
                mem_addr_d = mem_addr_q + 1'b1;
                mem_rd_d   = 1'b1;
            end
            if (out_cnt_q == 3'd0 && src_q == SRC_ID) id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
        end
    end

    assign qdo      = qdo_q;
    assign oe       = oe_q;
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: randomized and directed checks of the SPI flash responder against a transaction-level model.
module tb_spi_flash_responder;

    localparam logic [23:0] JID = 24'hEF4016;

    logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1;
    logic [3:0]  qdi = 4'h0;
    logic [3:0]  qdo, oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;

    int total = 0, bad = 0, rd_double = 0, addr_glitch = 0, oe_bad = 0;
    logic        rd_prev = 1'b0;
    logic [23:0] addr_prev = 24'h0;
    logic [7:0]  got[$];
    logic [23:0] rd_log[$];
    logic [7:0]  mem_ovr[int];

    spi_flash_responder dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .qdi(qdi),
        .qdo(qdo), .oe(oe), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endfunction

    // Memory port: data valid only in the cycle after the strobe, garbage otherwise.
    always @(posedge clk) mem_data <= mem_rd ? mem_byte(mem_addr) : 8'($urandom);

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_prev   <= 1'b0;
            addr_prev <= mem_addr;
        end else begin
            if (mem_rd) rd_log.push_back(mem_addr);
            if (mem_rd && rd_prev) rd_double <= rd_double + 1;
            if (mem_addr !== addr_prev && !mem_rd) addr_glitch <= addr_glitch + 1;
            rd_prev   <= mem_rd;
            addr_prev <= mem_addr;
        end
    end

    function automatic bit is_mem(input logic [7:0] op);
        return op == 8'h03 || op == 8'h0B || op == 8'h6B;
    endfunction
    function automatic bit has_dummy(input logic [7:0] op);
        return op == 8'h0B || op == 8'h6B;
    endfunction
    function automatic bit is_quad(input logic [7:0] op);
        return op == 8'h6B;
    endfunction
    function automatic bit is_known(input logic [7:0] op);
        return is_mem(op) || op == 8'h9F || op == 8'h05;
    endfunction

    // Byte i of the response stream for a command.
    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] a, input int i);
        if (is_mem(op)) return mem_byte(a + 24'(i));
        if (op == 8'h9F) return 8'(JID >> (8 * (2 - i % 3)));
        return 8'h00;
    endfunction

    task automatic clock_bit(input logic mosi, output logic [3:0] q, output logic [3:0] o);
        qdi = {3'b101, mosi};
        repeat (4) @(negedge clk);
        q = qdo;
        o = oe;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic begin_tx();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_tx();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_tx(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
        logic [3:0] q, o, mask;
        logic [7:0] v;
        got.delete();
        rd_log.delete();
        oe_bad = 0;
        mask = is_quad(op) ? 4'hF : 4'h2;
        begin_tx();
        for (int i = 7; i >= 0; i--) begin
            clock_bit(op[i], q, o);
            if (o !== 4'h0) oe_bad++;
        end
        if (is_mem(op)) for (int i = 23; i >= 0; i--) begin
            clock_bit(addr[i], q, o);
            if (o !== 4'h0) oe_bad++;
        end
        if (has_dummy(op)) for (int i = 0; i < 8; i++) begin
            clock_bit(1'($urandom), q, o);
            if (o !== 4'h0) oe_bad++;
        end
        for (int b = 0; b < nbytes; b++) begin
            v = 8'h00;
            for (int k = 0; k < (is_quad(op) ? 2 : 8); k++) begin
                clock_bit(1'($urandom), q, o);
                v = is_quad(op) ? {v[3:0], q} : {v[6:0], q[1]};
                if (o !== (is_known(op) ? mask : 4'h0)) oe_bad++;
            end
            if (is_known(op)) got.push_back(v);
        end
        end_tx();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({qdo, oe, mem_rd, mem_addr} !== '0)
            begin bad++; $display("FAIL reset: qdo=%h oe=%h rd=%b addr=%h required all 0", qdo, oe, mem_rd, mem_addr); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read();
        mem_ovr[16] = 8'hA5;
        mem_ovr[17] = 8'h3C;
        run_tx(8'h03, 24'h000010, 2);
        total++;
        if (got.size() != 2) begin bad++; $display("FAIL read_len: got %0d bytes required 2", got.size()); end
        else for (int i = 0; i < 2; i++) begin
            total++;
            if (got[i] !== exp_byte(8'h03, 24'h10, i)) begin bad++; $display("FAIL read_byte%0d: got %h required %h", i, got[i], exp_byte(8'h03, 24'h10, i)); end
        end
        total++;
        if (oe_bad != 0) begin bad++; $display("FAIL read_oe: %0d bad oe samples required 0", oe_bad); end
        total++;
        if (rd_log.size() < 3) begin bad++; $display("FAIL read_addr_cnt: %0d reads required >=3", rd_log.size()); end
        else for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_log[i] !== 24'h10 + 24'(i)) begin bad++; $display("FAIL read_addr%0d: got %h required %h", i, rd_log[i], 24'h10 + 24'(i)); end
        end
    endtask

    task automatic test_quad();
        mem_ovr[32] = 8'h5A;
        run_tx(8'h6B, 24'h000020, 1);
        total++;
        if (got.size() != 1 || got[0] !== 8'h5A) begin bad++; $display("FAIL quad_byte: got %h required 5a", got.size() ? got[0] : 8'hxx); end
        total++;
        if (oe_bad != 0) begin bad++; $display("FAIL quad_oe: %0d bad oe samples required 0", oe_bad); end
        total++;
        if (oe !== 4'h0) begin bad++; $display("FAIL quad_oe_after_cs: got %h required 0", oe); end
    endtask

    task automatic test_rdid();
        run_tx(8'h9F, 24'h0, 6);
        total++;
        if (got.size() != 6) begin bad++; $display("FAIL rdid_len: got %0d required 6", got.size()); end
        else for (int i = 0; i < 6; i++) begin
            total++;
            if (got[i] !== exp_byte(8'h9F, 24'h0, i)) begin bad++; $display("FAIL rdid_byte%0d: got %h required %h", i, got[i], exp_byte(8'h9F, 24'h0, i)); end
        end
        total++;
        if (rd_log.size() != 0) begin bad++; $display("FAIL rdid_memrd: %0d reads required 0", rd_log.size()); end
    endtask

    task automatic test_wrap();
        mem_ovr[24'hFFFFFF] = 8'($urandom);
        mem_ovr[0] = 8'($urandom);
        run_tx(8'h0B, 24'hFFFFFF, 2);
        total++;
        if (got.size() != 2 || got[0] !== mem_ovr[24'hFFFFFF] || got[1] !== mem_ovr[0])
            begin bad++; $display("FAIL wrap_data: got %p required %h %h", got, mem_ovr[24'hFFFFFF], mem_ovr[0]); end
        total++;
        if (rd_log.size() < 2 || rd_log[0] !== 24'hFFFFFF || rd_log[1] !== 24'h000000)
            begin bad++; $display("FAIL wrap_addr: got %p required ffffff 000000 first", rd_log); end
    endtask

    task automatic test_abort();
        logic [3:0] q, o;
        logic [7:0] op;
        logic [23:0] a;
        op = 8'h03;
        a = 24'hABCDEF;
        rd_log.delete();
        begin_tx();
        for (int i = 7; i >= 0; i--) clock_bit(op[i], q, o);
        for (int i = 23; i >= 12; i--) clock_bit(a[i], q, o);
        end_tx();
        total++;
        if (rd_log.size() != 0 || oe !== 4'h0) begin bad++; $display("FAIL abort_idle: reads=%0d oe=%h required 0 0", rd_log.size(), oe); end
        mem_ovr[4] = 8'($urandom);
        run_tx(8'h03, 24'h000004, 1);
        total++;
        if (got.size() != 1 || got[0] !== mem_ovr[4]) begin bad++; $display("FAIL abort_next: got %p required %h", got, mem_ovr[4]); end
        a = 24'h000040;
        begin_tx();
        for (int i = 7; i >= 0; i--) clock_bit(op[i], q, o);
        for (int i = 23; i >= 0; i--) clock_bit(a[i], q, o);
        for (int i = 0; i < 3; i++) clock_bit(1'b0, q, o);
        total++;
        if (oe !== 4'h2) begin bad++; $display("FAIL rst_pre_oe: got %h required 2", oe); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({qdo, oe, mem_rd, mem_addr} !== '0)
            begin bad++; $display("FAIL rst_mid: qdo=%h oe=%h rd=%b addr=%h required all 0", qdo, oe, mem_rd, mem_addr); end
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_unknown();
        run_tx(8'h02, 24'h0, 4);
        total++;
        if (oe_bad != 0 || rd_log.size() != 0) begin bad++; $display("FAIL unknown: oe_bad=%0d reads=%0d required 0 0", oe_bad, rd_log.size()); end
        run_tx(8'h05, 24'h0, 2);
        total++;
        if (got.size() != 2 || got[0] !== 8'h00 || got[1] !== 8'h00) begin bad++; $display("FAIL rdsr: got %p required 00 00", got); end
    endtask

    task automatic test_random();
        logic [7:0] ops[6];
        logic [7:0] op;
        logic [23:0] a;
        int n;
        ops = '{8'h03, 8'h0B, 8'h6B, 8'h9F, 8'h05, 8'h00};
        for (int t = 0; t < 24; t++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 8'h00) while (is_known(op)) op = 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) mem_ovr[int'(a + 24'(i))] = 8'($urandom);
            run_tx(op, a, n);
            total++;
            if (got.size() != (is_known(op) ? n : 0)) begin bad++; $display("FAIL rnd%0d_len op=%h: got %0d required %0d", t, op, got.size(), is_known(op) ? n : 0); end
            else for (int i = 0; i < got.size(); i++) begin
                total++;
                if (got[i] !== exp_byte(op, a, i)) begin bad++; $display("FAIL rnd%0d_byte%0d op=%h: got %h required %h", t, i, op, got[i], exp_byte(op, a, i)); end
            end
            total++;
            if (oe_bad != 0) begin bad++; $display("FAIL rnd%0d_oe op=%h: %0d bad samples required 0", t, op, oe_bad); end
            // One read for the address, then one per byte loaded; the trailing fall loads byte n too.
            total++;
            if (rd_log.size() != (is_mem(op) ? n + 2 : 0)) begin bad++; $display("FAIL rnd%0d_reads op=%h: got %0d required %0d", t, op, rd_log.size(), is_mem(op) ? n + 2 : 0); end
            else for (int i = 0; i < rd_log.size(); i++) begin
                total++;
                if (rd_log[i] !== a + 24'(i)) begin bad++; $display("FAIL rnd%0d_addr%0d: got %h required %h", t, i, rd_log[i], a + 24'(i)); end
            end
        end
    endtask

    task automatic test_protocol();
        total++;
        if (rd_double != 0) begin bad++; $display("FAIL mem_rd_back_to_back: %0d occurrences required 0", rd_double); end
        total++;
        if (addr_glitch != 0) begin bad++; $display("FAIL mem_addr_unstrobed: %0d changes required 0", addr_glitch); end
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read();
        test_quad();
        test_rdid();
        test_wrap();
        test_abort();
        test_unknown();
        test_random();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Synthesizable SPI-flash target that sits on the far side of the MCU's 6-wire flash interface (sclk, cs_n, io0..io3). It lets a test FPGA or a second MCU emulate the boot flash out of block RAM. It decodes a small read-only command set and fetches bytes through a one-cycle-latency memory read port. It is oversampled by the local system clock; SPI mode 0 only.

Parameters:
ADDR_BITS, 24, width of flash byte address; address counter wraps modulo 2^ADDR_BITS
JEDEC_ID, 24'hEF4016, 3-byte value returned by RDID (0x9F), MSB first
SYNC_STAGES, 2, synchronizer depth for sclk, cs_n and io0

Ports:
clk  input  1  system clock, at least 4x the sclk frequency
rst_n  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from the master, idle low
cs_n  input  1  SPI chip select from the master, active low
qdi  input  4  io3..io0 as seen at the pads; only qdi[0] (MOSI) is sampled
qdo  output  4  io3..io0 output data
oe  output  4  per-lane output enable, 1 = drive
mem_addr  output  ADDR_BITS  byte address to the backing memory
mem_rd  output  1  one-cycle read strobe
mem_data  input  8  read data, valid the clk cycle after mem_rd

Behaviour:
- Reset values: qdo=0, oe=0, mem_rd=0, mem_addr=0, state=IDLE, bit counter=0.
- sclk, cs_n and qdi[0] pass through SYNC_STAGES flops. A rising or falling sclk event is the synchronized sclk edge, qualified by synchronized cs_n=0.
- Mode 0 timing:
  - Sample qdi[0] on each rise event, MSB first.
  - Shift output on each fall event. The first output bit is driven on the fall event that follows the last input bit.
- States and transitions:
  - IDLE: on the cs_n fall event, go to CMD.
  - CMD: collect 8 bits, then decode the opcode:
    - 0x03 READ: go to ADDR, no dummy clocks, 1 lane.
    - 0x0B FAST READ: go to ADDR, 8 dummy clocks, 1 lane.
    - 0x6B QUAD OUTPUT READ: go to ADDR, 8 dummy clocks, 4 lanes.
    - 0x9F RDID: go to DOUT with source JEDEC_ID, 1 lane.
    - 0x05 RDSR: go to DOUT with source 8'h00, repeated, 1 lane.
    - Any other opcode: go to IGNORE.
  - ADDR: collect 24 bits MSB first; the low ADDR_BITS bits are kept.
    - On the last rise event, load mem_addr and pulse mem_rd.
    - Then go to DUMMY if the opcode has dummy clocks, else DOUT.
  - DUMMY: count 8 rise events, then go to DOUT. Outputs stay tri-stated during DUMMY.
  - DOUT: shift out the byte register MSB first.
    - 1-lane: qdo[1] carries the data (MISO), oe=4'b0010.
    - 4-lane: qdo[3:0] carries the nibble, high nibble first, oe=4'b1111.
    - When the byte register is loaded, increment mem_addr (with wrap) and pulse mem_rd to prefetch the next byte. Latch mem_data into the prefetch register one cycle later.
    - RDID cycles the 3 ID bytes and then repeats them.
  - IGNORE: no outputs, no memory reads, until cs_n rises.
- cs_n rise event in any state: within 1 clk go to IDLE, oe=0, bit counter=0, and drop any pending prefetch.
- A cs_n rise mid-byte or mid-address aborts the transaction; nothing is retained.
- rst_n assertion mid-transaction returns everything to reset values immediately (asynchronous).
- mem_rd is never high for two consecutive cycles. mem_addr stays stable except when mem_rd is pulsed.
- Address wrap: 0xFFFFFF+1 → 0x000000 when ADDR_BITS=24.
- oe changes only on fall events or on cs_n rise, never on rise events.

Decomposition:
- Shared package spi_flash_pkg holds:
  - opcode constants OP_READ=8'h03, OP_FREAD=8'h0B, OP_QREAD=8'h6B, OP_RDID=8'h9F, OP_RDSR=8'h05;
  - the state encoding (IDLE, CMD, ADDR, DUMMY, DOUT, IGNORE);
  - the dummy-clock count constant (8).
- One natural sub-module, spi_edge_sync: the parameterized synchronizer with rise/fall event outputs. It is instantiated for sclk and cs_n; a plain synchronizer is used for io0.

Test Plan:
- READ: 0x03, addr 0x000010; memory bytes 0x10,0x11 = 0xA5,0x3C → MISO shifts 10100101 00111100; mem_addr steps 0x10, 0x11, 0x12; oe=0010 only during data.
- QUAD READ: 0x6B, addr 0x000020, 8 dummy clocks, mem[0x20]=0x5A → io3..io0 = 0101 then 1010; oe=1111 from the first data fall event, 0 after cs_n rises.
- RDID: 0x9F with 48 clocks → EF 40 16 EF 40 16 on MISO; mem_rd never asserted.
- Wrap: FAST READ at 0xFFFFFF for 2 bytes → mem_addr goes 0xFFFFFF then 0x000000; data = mem[0xFFFFFF], mem[0].
- Abort: cs_n rises after 12 address bits, then a new READ at 0x000004 → correct mem[4]; no stale prefetch byte appears. Also pulse rst_n low mid-DOUT → all outputs 0 immediately.
- Unknown opcode 0x02 followed by 32 clocks → oe stays 0 and mem_rd stays 0; the next transaction (0x05) returns 0x00.
